div_24bits_seq: RTL and testbench

DIV_24BITS_SEQ -- requirements
Module: div_24bits_seq

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 32 +++
 rtl/div_24bits_seq.sv | 143 ++++++++++++++
 tb/tb_div_24bits_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential significand divider.
// Holds the default significand width, the iteration count and the FSM state type.
package div_pkg;

    // Significand width including the hidden bit.
    localparam int unsigned DIV_WIDTH = 24;
    // Restoring steps per division: one integer bit plus WIDTH+1 fraction bits.
    localparam int unsigned DIV_ITERS = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare, conditional subtract, shift left.
// Ports:
//   rem_i   - current partial remainder (WIDTH+1 bits)
//   div_i   - divisor significand (WIDTH bits)
//   rem_o   - next partial remainder, already shifted left by one
//   q_bit_o - quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] div_ext;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] sel;

    // The remainder before the shift is always below the divisor, so the
    // MSB dropped by the shift is zero and no information is lost.
    always_comb begin
        div_ext = {1'b0, div_i};
        diff    = rem_i - div_ext;
        q_bit_o = (rem_i >= div_ext);
        sel     = q_bit_o ? diff : rem_i;
        rem_o   = sel << 1;
    end

endmodule

// File: rtl/div_24bits_seq.sv
// Sequential restoring divider for normalized significands (1.xxx format).
// Produces a WIDTH+2 bit quotient (MSB weight 2^0, LSB weight 2^-(WIDTH+1))
// after WIDTH+2 iterations of a single shared compare/subtract/shift step.
// Ports:
//   i_clk, i_rst_n           - clock, synchronous active-low reset
//   i_valid / o_ready        - operand handshake (accepted only in IDLE)
//   i_data_one, i_data_two   - dividend and divisor significands
//   o_valid / i_ready        - result handshake (held in DONE until i_ready)
//   o_data                   - quotient
//   o_sticky                 - final remainder nonzero
//   o_div_zero               - divisor was zero (o_data forced to all ones)
module div_24bits_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_one,
    input  logic [WIDTH-1:0] i_data_two,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH+1:0] o_data,
    output logic             o_sticky,
    output logic             o_div_zero
);

    localparam int unsigned N_ITER = WIDTH + (DIV_ITERS - DIV_WIDTH);
    localparam int unsigned CNT_W  = $clog2(N_ITER);
    localparam int unsigned REM_W  = WIDTH + 1;
    localparam int unsigned QW     = WIDTH + 2;

    div_state_e       state_q,  state_d;
    logic [REM_W-1:0] rem_q,    rem_d;
    logic [WIDTH-1:0] div_q,    div_d;
    logic [QW-1:0]    quo_q,    quo_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             ready_q,  ready_d;
    logic             valid_q,  valid_d;
    logic             sticky_q, sticky_d;
    logic             dz_q,     dz_d;

    logic [REM_W-1:0] step_rem;
    logic             step_bit;

    // Single step instance, iterated once per CALC cycle.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i   (rem_q),
        .div_i   (div_q),
        .rem_o   (step_rem),
        .q_bit_o (step_bit)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    div_d    = i_data_two;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    if (i_data_two == '0) begin
                        state_d = DONE;
                        rem_d   = '0;
                        quo_d   = '1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                        rem_d   = {1'b0, i_data_one};
                        quo_d   = '0;
                        dz_d    = 1'b0;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[QW-2:0], step_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    sticky_d = |step_rem;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state decode.
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_data     = quo_q;
    assign o_sticky   = sticky_q;
    assign o_div_zero = dz_q;

endmodule

// File: tb/tb_div_24bits_seq.sv
// Directed self-checking bench for div_24bits_seq with a result scoreboard.
module tb_div_24bits_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [23:0] i_data_one;
    logic [23:0] i_data_two;
    logic        o_valid;
    logic        i_ready;
    logic [25:0] o_data;
    logic        o_sticky;
    logic        o_div_zero;

    typedef struct packed {
        logic [25:0] data;
        logic        sticky;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_24bits_seq #(.WIDTH(24)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_one (i_data_one),
        .i_data_two (i_data_two),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_sticky   (o_sticky),
        .o_div_zero (o_div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference quotient: floor(a * 2^25 / b), sticky when the division is inexact.
    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b);
        exp_t e;
        logic [63:0] n;
        logic [63:0] q;
        logic [63:0] r;
        if (b == 24'h0) begin
            e.data   = 26'h3FFFFFF;
            e.sticky = 1'b0;
            e.dz     = 1'b1;
        end else begin
            n        = 64'(a) << 25;
            q        = n / 64'(b);
            r        = n % 64'(b);
            e.data   = 26'(q);
            e.sticky = (r != 64'h0);
            e.dz     = 1'b0;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [23:0] a, input logic [23:0] b, output int acc);
        int n = 0;
        while (o_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(o_ready), 32'd1);
        i_data_one = a;
        i_data_two = b;
        i_valid    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        acc     = cyc;
    endtask

    task automatic get_result(input string tag, input int exp_lat, input bit chk_lat);
        int   n = 0;
        exp_t e;
        while (o_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        if (chk_lat) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_data"},   32'(o_data),     32'(e.data));
        chk({tag, "_sticky"}, 32'(o_sticky),   32'(e.sticky));
        chk({tag, "_dz"},     32'(o_div_zero), 32'(e.dz));
        chk({tag, "_ready_in_done"}, 32'(o_ready), 32'd0);
        if (i_ready) begin
            @(negedge clk);
            chk({tag, "_one_pulse"}, 32'(o_valid), 32'd0);
            chk({tag, "_back_idle"}, 32'(o_ready), 32'd1);
        end
    endtask

    initial begin
        int   acc1;
        int   acc2;
        int   seen;
        int   n;
        exp_t e;
        logic [23:0] ra;
        logic [23:0] rb;

        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_data_one = '0;
        i_data_two = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(o_ready),    32'd1);
        chk("rst_valid",  32'(o_valid),    32'd0);
        chk("rst_data",   32'(o_data),     32'd0);
        chk("rst_sticky", 32'(o_sticky),   32'd0);
        chk("rst_dz",     32'(o_div_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1.0 / 1.0 -> exactly 26'h2000000
        send(24'h800000, 24'h800000, acc1);
        get_result("one_one", 26, 1'b1);

        // 1.0 / 1.5 -> 26'h1555555, inexact
        send(24'h800000, 24'hC00000, acc1);
        get_result("one_1p5", 26, 1'b1);

        // Max / 1.0 = 2 - 2^-23, i.e. 26'h3FFFFFC at this quotient weighting;
        // then 1.5 / 1.0 issued as soon as the block is ready again.
        send(24'hFFFFFF, 24'h800000, acc1);
        get_result("max_one", 26, 1'b1);
        send(24'hC00000, 24'h800000, acc2);
        chk("throughput", 32'(acc2 - acc1), 32'd28);
        get_result("1p5_one", 26, 1'b1);

        // Divide by zero: result on the accept edge itself
        send(24'hA00000, 24'h000000, acc1);
        get_result("div_zero", 0, 1'b1);

        // Backpressure: hold DONE for 10 cycles
        i_ready = 1'b0;
        send(24'h900000, 24'hA00000, acc1);
        n = 0;
        while (o_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = sb[0];
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_data",  32'(o_data),  32'(e.data));
            chk("bp_ready", 32'(o_ready), 32'd0);
            @(negedge clk);
        end
        i_ready = 1'b1;
        get_result("bp_release", 0, 1'b0);

        // i_valid while busy is ignored
        send(24'hE00000, 24'h900000, acc1);
        i_valid    = 1'b1;
        i_data_one = 24'h800000;
        i_data_two = 24'h000000;
        repeat (3) @(negedge clk);
        i_valid = 1'b0;
        get_result("calc_ignore", 23, 1'b1);

        // Reset during CALC aborts with no result
        send(24'hF00000, 24'hB00000, acc1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready",  32'(o_ready),    32'd1);
        chk("abort_valid",  32'(o_valid),    32'd0);
        chk("abort_data",   32'(o_data),     32'd0);
        chk("abort_sticky", 32'(o_sticky),   32'd0);
        chk("abort_dz",     32'(o_div_zero), 32'd0);
        void'(sb.pop_front());
        rst_n = 1'b1;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        send(24'hAAAAAA, 24'h812345, acc1);
        get_result("post_reset", 26, 1'b1);

        // Random normalized operands
        for (int k = 0; k < 6; k++) begin
            ra = 24'h800000 | 24'($urandom);
            rb = 24'h800000 | 24'($urandom);
            send(ra, rb, acc1);
            get_result("random", 26, 1'b1);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
